// File: rtl/exhaustive_sweep_ctrl.sv
// ============================================================================
// Module   : exhaustive_sweep_ctrl
// Purpose  : Steps a W-input combinational lab unit through every input code,
//            captures its response and folds it into a 16-bit signature.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exhaustive_sweep_ctrl #(
    parameter int W     = 5,
    parameter int DWELL = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         step_mode,
    input  logic         step,
    input  logic         hold,
    input  logic [W-1:0] dut_out,
    output logic [W-1:0] dut_in,
    output logic         busy,
    output logic         done,
    output logic         cap_valid,
    output logic [W-1:0] cap_code,
    output logic [W-1:0] cap_data,
    output logic [15:0]  signature
);

    localparam logic [W-1:0] c_last_code = {W{1'b1}};
    localparam logic [7:0]   c_dwell_m1  = 8'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_CAPTURE   = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_begin;
    logic           w_advance;
    logic           w_capture;
    logic           w_settled;
    logic [W-1:0]   r_dut_in;
    logic [7:0]     r_cnt;
    logic           r_cap_valid;
    logic [W-1:0]   r_cap_code;
    logic [W-1:0]   r_cap_data;
    logic [15:0]    r_sig;

    assign w_settled = (r_cnt == c_dwell_m1) && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_begin     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (w_settled) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_capture = 1'b1;
                if (r_dut_in == c_last_code) begin
                    w_state_nxt = S_DONE;
                end else if (step_mode) begin
                    w_state_nxt = S_WAIT_STEP;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_advance   = 1'b1;
                end
            end
            S_WAIT_STEP: begin
                if (step) begin
                    w_state_nxt = S_SETTLE;
                    w_advance   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: code/counter sequencing plus capture and signature folding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dut_in    <= '0;
            r_cnt       <= '0;
            r_cap_valid <= 1'b0;
            r_cap_code  <= '0;
            r_cap_data  <= '0;
            r_sig       <= '0;
        end else begin
            r_cap_valid <= w_capture;
            if (w_begin) begin
                r_dut_in <= '0;
                r_cnt    <= '0;
                r_sig    <= '0;
            end else if (w_advance) begin
                r_dut_in <= r_dut_in + W'(1);
                r_cnt    <= '0;
            end else if (r_state == S_SETTLE && !hold && !w_settled) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) begin
                r_cap_data <= dut_out;
                r_cap_code <= r_dut_in;
                r_sig      <= {r_sig[14:0], r_sig[15]} ^ {{(16-W){1'b0}}, dut_out};
            end
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = (r_state == S_SETTLE) || (r_state == S_CAPTURE) ||
                       (r_state == S_WAIT_STEP);
    assign done      = (r_state == S_DONE);
    assign cap_valid = r_cap_valid;
    assign cap_code  = r_cap_code;
    assign cap_data  = r_cap_data;
    assign signature = r_sig;

endmodule

`default_nettype wire
